// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Arbiter FSM states and the RISC-V NOP used as the fetch fallback.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_DATA,
    ARB_FETCH,
    ARB_DONE
  } arb_state_e;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Request watchdog: counts unacknowledged request cycles and
// fakes an ack after TIMEOUT_CYCLES; sticky flag until reset.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expire,
  output logic o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_flag;

  assign o_expire  = i_wait &
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout = r_flag;

  // Count waiting cycles; restart on every new access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_flag <= 1'b0;
    end else begin
      if (i_clear || o_expire) begin
        r_cnt <= '0;
      end else if (i_wait) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (o_expire) begin
        r_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory; data goes first.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_timeout
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              r_if_req;
  logic [ADDR_W-1:0] r_if_addr;
  logic              r_dm_we;
  logic [ADDR_W-1:0] r_dm_addr;
  logic [DATA_W-1:0] r_dm_wdata;
  logic              r_mem_req;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              w_ack;
  logic              w_expire;
  logic              w_fin;
  logic              w_latch;
  logic              w_stall;

  assign w_ack   = r_mem_req & i_mem_ack;
  assign w_fin   = w_ack | w_expire;
  assign w_latch = (r_state == ARB_IDLE) &
                   (i_if_req | i_dm_req);

  assign o_mem_req  = r_mem_req;
  assign o_if_rdata = r_if_rdata;
  assign o_dm_rdata = r_dm_rdata;
  assign o_stall    = rst & w_stall;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (~r_mem_req | w_ack),
    .i_wait   (r_mem_req & ~i_mem_ack),
    .o_expire (w_expire),
    .o_timeout(o_timeout)
  );
`else
  logic w_unused_to;
  assign w_unused_to = ^TIMEOUT_CYCLES;
  assign w_expire    = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // Next state and pipeline stall.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        w_stall = i_if_req | i_dm_req;
        if (i_dm_req) begin
          w_next = ARB_DATA;
        end else if (i_if_req) begin
          w_next = ARB_FETCH;
        end
      end
      ARB_DATA: begin
        w_stall = 1'b1;
        if (w_fin) begin
          w_next = r_if_req ? ARB_FETCH : ARB_DONE;
        end
      end
      ARB_FETCH: begin
        w_stall = 1'b1;
        if (w_fin) begin
          w_next = ARB_DONE;
        end
      end
      ARB_DONE: begin
        w_next = ARB_IDLE;
      end
      default: begin
        w_next = ARB_IDLE;
      end
    endcase
  end

  // Memory-side address/control from the pending access.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (r_state == ARB_DATA) begin
      o_mem_we    = r_dm_we;
      o_mem_addr  = r_dm_addr;
      o_mem_wdata = r_dm_wdata;
    end else if (r_state == ARB_FETCH) begin
      o_mem_addr = r_if_addr;
    end
  end

  // State, pending requests, request line and read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ARB_IDLE;
      r_if_req   <= 1'b0;
      r_if_addr  <= '0;
      r_dm_we    <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_mem_req  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= (w_next == ARB_DATA) ||
                   (w_next == ARB_FETCH);
      if (w_latch) begin
        r_if_req   <= i_if_req;
        r_if_addr  <= i_if_addr;
        r_dm_we    <= i_dm_we;
        r_dm_addr  <= i_dm_addr;
        r_dm_wdata <= i_dm_wdata;
      end
      if (w_fin && r_state == ARB_DATA && !r_dm_we) begin
        r_dm_rdata <= w_ack ? i_mem_rdata : '0;
      end
      if (w_fin && r_state == ARB_FETCH) begin
        r_if_rdata <= w_ack ? i_mem_rdata
                            : DATA_W'(RV_NOP);
      end
    end
  end

endmodule
